// File: rtl/gray_counter.sv
// Up/down counter that keeps the binary count as state and registers its Gray
// equivalent on the same edge, so the two outputs always agree.
module gray_counter #(
    parameter int DATA = 4,
    parameter int SAT  = 0,
    parameter int INIT = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            up,
    input  logic            load,
    input  logic [DATA-1:0] load_val,
    output logic [DATA-1:0] gray,
    output logic [DATA-1:0] bin,
    output logic            tc,
    output logic            wrap
);

    localparam logic [DATA-1:0] MAX_VAL   = {DATA{1'b1}};
    localparam logic [DATA-1:0] ONE       = {{(DATA-1){1'b0}}, 1'b1};
    localparam logic [DATA-1:0] INIT_BIN  = DATA'(INIT);
    localparam logic [DATA-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);

    logic [DATA-1:0] bin_reg;
    logic [DATA-1:0] bin_next;
    logic [DATA-1:0] gray_reg;
    logic [DATA-1:0] gray_next;
    logic            wrap_reg;
    logic            wrap_next;
    logic            at_max;
    logic            at_min;

    assign at_max = (bin_reg == MAX_VAL);
    assign at_min = (bin_reg == '0);

    // Load beats enable; a range-end step either wraps (pulsing wrap) or holds.
    always_comb begin
        bin_next  = bin_reg;
        wrap_next = 1'b0;
        if (load) begin
            bin_next = load_val;
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    bin_next = bin_reg + ONE;
                end else if (SAT == 0) begin
                    bin_next  = '0;
                    wrap_next = 1'b1;
                end
            end else begin
                if (!at_min) begin
                    bin_next = bin_reg - ONE;
                end else if (SAT == 0) begin
                    bin_next  = MAX_VAL;
                    wrap_next = 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA - 1; gi++) begin : g_gray
            assign gray_next[gi] = bin_next[gi] ^ bin_next[gi+1];
        end
    endgenerate
    assign gray_next[DATA-1] = bin_next[DATA-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_reg  <= INIT_BIN;
            gray_reg <= INIT_GRAY;
            wrap_reg <= 1'b0;
        end else begin
            bin_reg  <= bin_next;
            gray_reg <= gray_next;
            wrap_reg <= wrap_next;
        end
    end

    // gray and wrap come straight from flops; only tc looks at a live input.
    assign gray = gray_reg;
    assign bin  = bin_reg;
    assign wrap = wrap_reg;
    assign tc   = up ? at_max : at_min;

endmodule

// File: tb/tb_gray_counter.sv
// Drives four counter variants from shared stimulus and checks every cycle
// against an arithmetic model, plus literal expectations for known sequences.
module tb_gray_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [6:0] lv;

    logic [3:0] g0, b0, g1, b1, g2, b2;
    logic [6:0] g3, b3;
    logic       t0, t1, t2, t3;
    logic       w0, w1, w2, w3;

    gray_counter #(.DATA(4), .SAT(0), .INIT(0)) u_wrap4 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(lv[3:0]), .gray(g0), .bin(b0), .tc(t0), .wrap(w0));
    gray_counter #(.DATA(4), .SAT(1), .INIT(0)) u_sat4 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(lv[3:0]), .gray(g1), .bin(b1), .tc(t1), .wrap(w1));
    gray_counter #(.DATA(4), .SAT(0), .INIT(9)) u_init9 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(lv[3:0]), .gray(g2), .bin(b2), .tc(t2), .wrap(w2));
    gray_counter #(.DATA(7), .SAT(0), .INIT(0)) u_wrap7 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(lv), .gray(g3), .bin(b3), .tc(t3), .wrap(w3));

    logic [6:0] dg [4];
    logic [6:0] db [4];
    logic       dt [4];
    logic       dw [4];
    assign dg[0] = {3'b000, g0};
    assign dg[1] = {3'b000, g1};
    assign dg[2] = {3'b000, g2};
    assign dg[3] = g3;
    assign db[0] = {3'b000, b0};
    assign db[1] = {3'b000, b1};
    assign db[2] = {3'b000, b2};
    assign db[3] = b3;
    assign dt[0] = t0;
    assign dt[1] = t1;
    assign dt[2] = t2;
    assign dt[3] = t3;
    assign dw[0] = w0;
    assign dw[1] = w1;
    assign dw[2] = w2;
    assign dw[3] = w3;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    int width_of [4] = '{4, 4, 4, 7};
    int sat_of   [4] = '{0, 1, 0, 0};
    int init_of  [4] = '{0, 0, 9, 0};

    int m_bin  [4];
    bit m_wrap [4];
    bit m_disc [4];
    logic [6:0] prev_gray [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int from_gray(input logic [6:0] g, input int w);
        int b = 0;
        for (int i = w - 1; i >= 0; i--) begin
            b = b | ((((b >> (i + 1)) & 1) ^ int'(g[i])) << i);
        end
        return b;
    endfunction

    // Reference: count in plain integers, fold back into range on crossing.
    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 4; k++) begin
            int span;
            int nxt;
            span = 1 << width_of[k];
            if (reset) begin
                m_bin[k]  = init_of[k];
                m_wrap[k] = 1'b0;
                m_disc[k] = 1'b1;
            end else if (load) begin
                m_bin[k]  = int'(lv) % span;
                m_wrap[k] = 1'b0;
                m_disc[k] = 1'b1;
            end else begin
                m_disc[k] = 1'b0;
                m_wrap[k] = 1'b0;
                if (en) begin
                    nxt = up ? m_bin[k] + 1 : m_bin[k] - 1;
                    if (nxt < 0 || nxt >= span) begin
                        if (sat_of[k] == 0) begin
                            m_bin[k]  = (nxt + span) % span;
                            m_wrap[k] = 1'b1;
                        end
                    end else begin
                        m_bin[k] = nxt;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 4; k++) begin
                int top;
                top = (1 << width_of[k]) - 1;
                chk($sformatf("bin[%0d]", k), 32'(db[k]), 32'(m_bin[k]));
                chk($sformatf("gray[%0d]", k), 32'(dg[k]), 32'(to_gray(m_bin[k])));
                chk($sformatf("wrap[%0d]", k), 32'(dw[k]), 32'(m_wrap[k]));
                chk($sformatf("tc[%0d]", k), 32'(dt[k]),
                    32'(up ? (m_bin[k] == top) : (m_bin[k] == 0)));
                chk($sformatf("decode[%0d]", k), 32'(from_gray(dg[k], width_of[k])), 32'(db[k]));
                if (!m_disc[k]) begin
                    chk($sformatf("hamming[%0d]", k),
                        32'($countones(dg[k] ^ prev_gray[k]) <= 1), 32'd1);
                end
                prev_gray[k] = dg[k];
            end
        end
    end

    task automatic cyc(input bit e, input bit u, input bit l, input logic [6:0] v);
        en   = e;
        up   = u;
        load = l;
        lv   = v;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] gseq [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        up    = 1'b0;
        load  = 1'b0;
        lv    = '0;
        #2 reset = 1'b1;
        #1 chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bin0", 32'(b0), 32'd0);
        chk("rst_gray0", 32'(g0), 32'd0);
        chk("rst_wrap0", 32'(w0), 32'd0);
        chk("rst_bin9", 32'(b2), 32'd9);
        chk("rst_gray9", 32'(g2), 32'hD);
        reset = 1'b0;

        chk("seq_gray_start", 32'(g0), 32'(gseq[0]));
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 7'd0);
            chk($sformatf("seq_gray_%0d", i + 1), 32'(g0), 32'(gseq[i+1]));
            chk($sformatf("seq_wrap_%0d", i + 1), 32'(w0), 32'(i == 15));
            chk($sformatf("seq_tc_%0d", i + 1), 32'(t0), 32'(i == 14));
        end

        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 7'd0);
        chk("down_bin", 32'(b0), 32'd15);
        chk("down_gray", 32'(g0), 32'h8);
        chk("down_wrap", 32'(w0), 32'd1);
        chk("down_sat_bin", 32'(b1), 32'd0);
        chk("down_sat_gray", 32'(g1), 32'd0);
        chk("down_sat_wrap", 32'(w1), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 7'd0);
        chk("down_wrap_gone", 32'(w0), 32'd0);
        chk("down_hold_bin", 32'(b0), 32'd15);
        cyc(1'b1, 1'b1, 1'b0, 7'd0);
        chk("wrap_before_rst", 32'(w0), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_bin9", 32'(b2), 32'd9);
        chk("async_gray9", 32'(g2), 32'hD);
        chk("async_wrap9", 32'(w2), 32'd0);
        chk("async_wrap0", 32'(w0), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        cyc(1'b1, 1'b1, 1'b1, 7'd5);
        chk("load5_bin", 32'(b0), 32'd5);
        chk("load5_gray", 32'(g0), 32'h7);
        chk("load5_wrap", 32'(w0), 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 7'd15);
        chk("load15_bin", 32'(b0), 32'd15);
        chk("load15_wrap", 32'(w0), 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 7'd0);
        chk("load0_bin", 32'(b0), 32'd0);
        chk("load0_wrap", 32'(w0), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 9) == 0,
                7'($urandom));
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
